// File: rtl/hi_lo_muldiv.sv
// -----------------------------------------------------------------------------
// hi_lo_muldiv
//   HI/LO register pair with an iterative multiply/divide unit for the MIPS core.
//   MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both work on
//   operand magnitudes, and the result signs are fixed up on commit. A normal
//   operation takes WIDTH iteration cycles after the start edge.
//
//   Optional feature macro: HILO_FAST_MULT_EN
//     defined   -> MULT/MULTU commit one cycle after start (busy high 1 cycle)
//     undefined -> all four operations take WIDTH iteration cycles
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (abandons any operation in flight)
//   start     issue op; sampled only while busy=0
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b      rs / rt operands, latched on the start edge
//   H_LWrite  MTHI/MTLO write enable (ignored while busy or when start is high)
//   H_LReg    1 selects HI, 0 selects LO for both write and read
//   wdata     MTHI/MTLO data
//   rdata     H_LReg ? HI : LO, combinational from the registers
//   busy      operation in progress
//   done      one-cycle pulse: HI/LO were just updated by a mul/div
// -----------------------------------------------------------------------------
module hi_lo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             H_LWrite,
  input  logic             H_LReg,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Architectural and control state
  logic [0:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;
  logic             done_q,    done_d;

  // Latched operation descriptor
  logic             is_div_q,  is_div_d;
  logic             neg_q,     neg_d;      // negate product / quotient on commit
  logic             rem_neg_q, rem_neg_d;  // remainder takes the dividend's sign
  logic             dz_q,      dz_d;       // divide by zero

  // Working datapath: opnd is the multiplicand or divisor magnitude.
  // acc_hi is the partial product high half or the partial remainder.
  // acc_lo holds the multiplier bits or the dividend bits, which are gradually
  // replaced by product or quotient bits.
  logic [WIDTH-1:0] opnd_q,    opnd_d;
  logic [WIDTH-1:0] acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q,  acc_lo_d;

  // Start-edge operand conditioning
  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // One iteration step
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_hi_nx, acc_lo_nx;

  // Commit values
  logic [2*WIDTH-1:0] mul_prod, mul_res;
  logic [WIDTH-1:0]   quo_res, rem_res;
  logic               last_iter;

  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    mag_a     = a_neg ? -a : a;
    mag_b     = b_neg ? -b : b;
  end

  // NOTE: every signal assigned in an always_comb gets a default at the top.
  // Otherwise a path that leaves a signal unassigned would infer a latch.
  always_comb begin
    acc_hi_nx = acc_hi_q;
    acc_lo_nx = acc_lo_q;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // Bit WIDTH of the difference is the borrow. It is set when the shifted
    // remainder is smaller than the divisor.
    div_diff  = div_shift - {1'b0, opnd_q};

    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        acc_hi_nx = div_diff[WIDTH-1:0];
        acc_lo_nx = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_nx = div_shift[WIDTH-1:0];
        acc_lo_nx = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_nx = mul_sum[WIDTH:1];
      acc_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

`ifdef HILO_FAST_MULT_EN
  // Multiplies finish on their first iteration edge using a full-width product.
  assign mul_prod  = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_lo_q};
  assign last_iter = (cnt_q == LAST_ITER) || !is_div_q;
`else
  assign mul_prod  = {acc_hi_nx, acc_lo_nx};
  assign last_iter = (cnt_q == LAST_ITER);
`endif

  always_comb begin
    mul_res = neg_q ? -mul_prod : mul_prod;
    // A zero divisor naturally leaves the dividend magnitude as the remainder,
    // so re-applying the dividend's sign restores a. Only LO needs forcing.
    quo_res = dz_q ? '1 : (neg_q ? -acc_lo_nx : acc_lo_nx);
    rem_res = rem_neg_q ? -acc_hi_nx : acc_hi_nx;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // If start and H_LWrite arrive in the same cycle, start wins and
          // the MTHI/MTLO write is dropped.
          state_d   = ST_RUN;
          cnt_d     = '0;
          is_div_d  = op[1];
          neg_d     = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          dz_d      = op[1] && (b == '0);
          acc_hi_d  = '0;
          if (op[1]) begin
            opnd_d   = mag_b;
            acc_lo_d = mag_a;
          end else begin
            opnd_d   = mag_a;
            acc_lo_d = mag_b;
          end
        end else if (H_LWrite) begin
          if (H_LReg) hi_d = wdata;
          else        lo_d = wdata;
        end
      end
      default: begin
        acc_hi_d = acc_hi_nx;
        acc_lo_d = acc_lo_nx;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_res;
            lo_d = quo_res;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  // Every flop updates from pre-edge values, so the result does not depend on
  // the order in which always blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
    end
  end

  assign rdata = H_LReg ? hi_q : lo_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_hi_lo_muldiv.sv
// -----------------------------------------------------------------------------
// tb_hi_lo_muldiv
//   Self-checking bench for hi_lo_muldiv (WIDTH=32). It applies a table of
//   directed vectors, several hand-written sequences for reset, MTHI/MTLO and
//   issue-while-busy corner cases, and randomized operations. Results are
//   checked against a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_hi_lo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         H_LWrite;
  logic         H_LReg;
  logic [W-1:0] wdata;
  logic [W-1:0] rdata;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  hi_lo_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .H_LWrite (H_LWrite),
    .H_LReg   (H_LReg),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the architectural result of each op in plain arithmetic
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint      sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    case (o)
      2'd0: begin sp = sa * sb; {hi, lo} = sp; end
      2'd1: begin up = {32'b0, x} * {32'b0, y}; {hi, lo} = up; end
      2'd2: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
      end
      default: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
    endcase
  endfunction

  function automatic int exp_cycles(input logic [1:0] o);
`ifdef HILO_FAST_MULT_EN
    return o[1] ? W : 1;
`else
    return W;
`endif
  endfunction

  task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
    H_LReg = 1'b1; #1; hi = rdata;
    H_LReg = 1'b0; #1; lo = rdata;
  endtask

  // Counts the falling edges on which busy is high, bounded by 100.
  // On return the bench sits on the first falling edge with busy low.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Issues one op, scrambles the operand inputs after the start edge, then
  // checks busy length, the done pulse and the committed HI/LO values.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    logic [W-1:0] hi, lo;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    wait_busy(n);
    check({name, " busy_cycles"}, 64'(n), 64'(exp_cycles(o)));
    check({name, " done"}, 64'(done), 64'd1);
    read_hilo(hi, lo);
    check({name, " HI"}, 64'(hi), 64'(ehi));
    check({name, " LO"}, 64'(lo), 64'(elo));
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] hi, lo, ehi, elo;
    logic [1:0]   o;
    logic [W-1:0] x, y;
    int           n;
    bit           saw_done;

    reset_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    H_LWrite = 1'b0; H_LReg = 1'b0; wdata = '0;

    vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{2'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9] = '{2'd1, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    read_hilo(hi, lo);
    check("reset HI", 64'(hi), 64'd0);
    check("reset LO", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI then MFHI, MTLO then MFLO
    @(negedge clk);
    H_LWrite = 1'b1; H_LReg = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    H_LWrite = 1'b0; H_LReg = 1'b0; wdata = 32'h5678;
    H_LWrite = 1'b1;
    @(negedge clk);
    H_LWrite = 1'b0;
    read_hilo(hi, lo);
    check("mthi HI", 64'(hi), 64'h1234);
    check("mtlo LO", 64'(lo), 64'h5678);

    // MTHI dropped when issued alongside start; MTLO ignored while busy
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd7;
    H_LWrite = 1'b1; H_LReg = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    start = 1'b0; H_LWrite = 1'b0;
    repeat (3) @(negedge clk);
    H_LWrite = 1'b1; H_LReg = 1'b0; wdata = 32'hDEAD;
    @(negedge clk);
    H_LWrite = 1'b0;
    wait_busy(n);
    check("mt_busy done", 64'(done), 64'd1);
    read_hilo(hi, lo);
    check("mt_busy HI", 64'(hi), 64'd6);
    check("mt_busy LO", 64'(lo), 64'd142);

    // Second start mid-operation is ignored
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd1000; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_busy(n);
    check("ign_start busy_cycles", 64'(n + 5), 64'(W));
    read_hilo(hi, lo);
    check("ign_start HI", 64'(hi), 64'd1);
    check("ign_start LO", 64'(lo), 64'd111);
    @(negedge clk);
    check("ign_start no_restart", 64'(busy), 64'd0);

    // Back-to-back: new start accepted on the cycle done is high
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_busy(n);
    check("b2b first done", 64'(done), 64'd1);
    read_hilo(hi, lo);
    check("b2b first LO", 64'(lo), 64'd42);
    start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd8;
    @(negedge clk);
    start = 1'b0;
    wait_busy(n);
    check("b2b second busy_cycles", 64'(n), 64'(W));
    check("b2b second done", 64'(done), 64'd1);
    read_hilo(hi, lo);
    check("b2b second HI", 64'(hi), 64'd2);
    check("b2b second LO", 64'(lo), 64'd6);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = '0;
        1: y = 32'($urandom_range(1, 15));
        2: x = 32'h80000000;
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      model(o, x, y, ehi, elo);
      run_op($sformatf("rand%0d op%0d a=%0h b=%0h", i, o, x, y), o, x, y, ehi, elo);
    end

    // Reset mid-DIVU: the operation is abandoned and never commits
    run_op("pre_reset", 2'd1, 32'h10001, 32'h10001, 32'h1, 32'h00020001);
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'hFFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid done", 64'(done), 64'd0);
    read_hilo(hi, lo);
    check("rst_mid HI", 64'(hi), 64'd0);
    check("rst_mid LO", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("rst_mid no_commit", 64'(saw_done), 64'd0);
    read_hilo(hi, lo);
    check("rst_mid HI after", 64'(hi), 64'd0);
    check("rst_mid LO after", 64'(lo), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
